// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, N async read ports, optional zero entry and bypass.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int R0_ZERO = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     busy_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {CLEAR, READY} state_t;
    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              w0_en, w1_en;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            busy_o  <= 1'b1;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (&clr_ptr) begin
                state  <= READY;
                busy_o <= 1'b0;
            end
        end
    end
    // port 1 wins an address collision, so port 0 is suppressed rather than ordered
    always_comb begin
        w1_en = !rst_i && state == READY && we1_i && !(R0_ZERO != 0 && waddr1_i == '0);
        w0_en = !rst_i && state == READY && we0_i && !(R0_ZERO != 0 && waddr0_i == '0)
                && !(we1_i && waddr0_i == waddr1_i);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (w1_en) mem[waddr1_i] <= wdata1_i;
            if (w0_en) mem[waddr0_i] <= wdata0_i;
        end
    end
    genvar k;
    for (k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr_i[k*ADDR_W +: ADDR_W];
        assign rdata_o[k*DATA_W +: DATA_W] =
            (busy_o || (R0_ZERO != 0 && ra == '0))     ? '0 :
            (BYPASS != 0 && we1_i && waddr1_i == ra)   ? wdata1_i :
            (BYPASS != 0 && we0_i && waddr0_i == ra)   ? wdata0_i :
            mem[ra];
    end
endmodule
